// File: rtl/klp32_pkg.sv
// Shared types and constants for the KLP32 front end.
package klp32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/klp32_sync_fifo.sv
// Synchronous FIFO with flush; storage is not reset, only pointers and count.
module klp32_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/klp32_fetch_unit.sv
// KLP32 fetch stage: owns the fetch PC, keeps at most one imem read in flight,
// and buffers returned {pc, inst} pairs for decode.
module klp32_fetch_unit
    import klp32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_req_pc;
    logic [31:0]  w_redirect_pc;
    logic [CW-1:0] w_fifo_count;
    logic         w_pop;
    logic         w_push;
    logic         w_room;
    logic         w_can_issue;
    logic         w_gnt;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_redirect_pc = i_redirect_pc & ~32'h3;
    assign o_inst_valid  = (w_fifo_count != '0);
    assign w_pop         = o_inst_valid & i_inst_ready;
    // An outstanding request already owns a slot, so a new one needs occ - pop < depth.
    assign w_room = (32'(w_fifo_count) + 32'(r_state != IDLE)) < (32'(FIFO_DEPTH) + 32'(w_pop));
    assign w_can_issue = reset & ~i_redirect & ((r_state == IDLE) | i_imem_rvalid) & w_room;
    assign w_gnt = w_can_issue & i_imem_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // A response landing in the redirect cycle completes the request, so nothing is left to drop.
    always_comb begin
        w_state_nxt = r_state;
        if (i_redirect)
            w_state_nxt = (r_state != IDLE && !i_imem_rvalid) ? DROP : IDLE;
        else if (w_gnt)
            w_state_nxt = WAIT;
        else if (r_state != IDLE && i_imem_rvalid)
            w_state_nxt = IDLE;
    end

    always_comb begin
        o_imem_req        = w_can_issue;
        o_imem_addr       = r_fetch_pc;
        w_push            = (r_state == WAIT) & i_imem_rvalid & ~i_redirect;
        w_push_entry.pc   = r_req_pc;
        w_push_entry.inst = i_imem_rdata;
        o_inst            = o_inst_valid ? w_head.inst : NOP_INST;
        o_inst_pc         = o_inst_valid ? w_head.pc   : RESET_PC;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          r_fetch_pc <= RESET_PC;
        else if (i_redirect) r_fetch_pc <= w_redirect_pc;
        else if (w_gnt)      r_fetch_pc <= r_fetch_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (w_gnt) r_req_pc <= r_fetch_pc;
    end

    klp32_sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_count (w_fifo_count)
    );

endmodule

// File: doc/klp32_fetch_unit.md
# klp32_fetch_unit

Instruction fetch stage for the KLP32 core. It owns the fetch PC, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small FIFO. The decode/execute stage pops instructions through a valid/ready handshake and redirects fetch on taken branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (word-aligned)
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- o_imem_req  out  1  read request to instruction memory
- o_imem_addr  out  32  word address of request, bits[1:0]=0
- i_imem_gnt  in  1  request accepted this cycle
- i_imem_rvalid  in  1  read data valid
- i_imem_rdata  in  32  returned instruction word
- i_redirect  in  1  one-cycle pulse: flush, refetch from i_redirect_pc
- i_redirect_pc  in  32  redirect target; bits[1:0] ignored (forced 0)
- o_inst_valid  out  1  FIFO head valid
- o_inst  out  32  FIFO head instruction
- o_inst_pc  out  32  PC of FIFO head
- i_inst_ready  in  1  consumer accepts head this cycle

## Operation
- Registers: fetch_pc, FIFO {pc, inst} × FIFO_DEPTH, count, state.
- States: IDLE (nothing outstanding), WAIT (one request outstanding, keep response), DROP (one outstanding, discard response). At most one outstanding request.
- pop = o_inst_valid & i_inst_ready. occ = count + (state != IDLE).
- can_issue = reset deasserted & !i_redirect & (state==IDLE | i_imem_rvalid) & (occ − pop < FIFO_DEPTH, counting rvalid push).
- o_imem_req = can_issue; o_imem_addr = fetch_pc. Once asserted, req and addr hold until i_imem_gnt unless a redirect arrives.
- On gnt: fetch_pc += 4 (wraps modulo 2^32); next state WAIT.
- On rvalid in WAIT: push {pc_of_request, i_imem_rdata}; state → IDLE unless a new grant occurs the same cycle (stays WAIT).
- On rvalid in DROP: data discarded; state → IDLE (or WAIT if granted the same cycle).
- On i_redirect: FIFO flushed (count=0, o_inst_valid=0 next cycle); fetch_pc = {i_redirect_pc[31:2],2'b00}; WAIT → DROP; DROP stays DROP; rvalid in the redirect cycle is discarded; pop in the redirect cycle still counts as consumed.
- Push and pop in the same cycle: count unchanged. A push into a full FIFO cannot occur by construction; the bench asserts on it.
- rvalid in IDLE is a protocol error: ignored.

## Timing
- Reset values: fetch_pc=RESET_PC, state=IDLE, count=0, o_inst_valid=0, o_imem_req=0 while reset low, o_inst=32'h0000_0013 (NOP), o_inst_pc=RESET_PC.
- First o_imem_req is in the first cycle after reset deasserts, with addr RESET_PC.
- Request granted in cycle N → rvalid no earlier than N+1 → o_inst_valid in the cycle after rvalid (registered, no bypass).
- Zero-wait memory (gnt always 1, rvalid at N+1), consumer always ready: one instruction per cycle in steady state.
- Redirect in cycle R → req for the target in R+1 (if no response is outstanding) → earliest o_inst_valid in R+3.
- Reset asserted mid-operation: all state clears immediately; an outstanding memory response after release arrives in IDLE and is ignored.

## Structure
- klp32_pkg: XLEN=32, NOP_INST=32'h0000_0013, fetch_state_e {IDLE, WAIT, DROP}.
- Sub-module klp32_sync_fifo (parameterised WIDTH/DEPTH; push, pop, flush, count, async active-low reset) holds {pc, inst}. The fetch unit contains the FSM and PC logic.

## Test plan
- Reset with RESET_PC=32'h100: outputs at reset values; first req addr=32'h100; memory returns 32'h00500513 → o_inst=32'h00500513, o_inst_pc=32'h100.
- Zero-wait stream of 8 words, ready=1: o_inst_pc sequence 0x0,0x4,…,0x1C on consecutive cycles, one per cycle.
- Backpressure with ready=0: exactly 2 entries buffered, req low; ready=1 → both popped in order (pc 0x0, 0x4), req resumes at addr 0x8.
- Redirect to 32'h42 while a request is outstanding: response dropped; next req addr=32'h40; first popped o_inst_pc=32'h40.
- Redirect coinciding with rvalid and pop: rvalid data discarded, popped instruction consumed, FIFO empty next cycle.
- Async reset asserted mid-stream, then released: count=0, o_inst_valid=0, req restarts at RESET_PC; the stale rvalid is ignored.
